uart_rx_frame: RTL and testbench

UART receiver: the stage that consumes the 8N1 serial stream produced by the team's UART transmitter (loopback or an external link), and the mirror of that transmitter. It synchronises the asynchronous serial input, validates the start bit at mid-bit, and samples eight data bits LSB-first at bit centres. It checks the stop bit and hands each byte downstream with a one-cycle valid pulse, or flags a framing error.

---
 rtl/uart_rx_frame.sv | 132 +++++++++++++
 tb/tb_uart_rx_frame.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, centre sampling
// of eight LSB-first data bits, stop-bit check with valid / framing-error pulses.
module uart_rx_frame #(
    parameter int baudrate       = 115_200,
    parameter int base_clk       = 50_000_000,
    parameter int clocks_per_bit = base_clk / baudrate
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_data_serial,
    output logic [7:0] out_data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int          half_bit = clocks_per_bit / 2;
    localparam logic [31:0] half_m1  = 32'(half_bit - 1);
    localparam logic [31:0] bit_m1   = 32'(clocks_per_bit - 1);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    rx_state_t   state;
    logic        rx_meta_r;
    logic        rx_s;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    // Two-stage synchroniser for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= input_data_serial;
            rx_s      <= rx_meta_r;
        end
    end

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RX_IDLE;
            cnt           <= 32'd0;
            bit_idx       <= 3'd0;
            shreg         <= 8'd0;
            out_data      <= 8'd0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt     <= 32'd0;
                    bit_idx <= 3'd0;
                    if (!rx_s) begin
                        state <= RX_START;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RX_START: begin
                    if (cnt == half_m1) begin
                        cnt <= 32'd0;
                        if (!rx_s) begin
                            state <= RX_DATA;
                        end else begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == bit_m1) begin
                        cnt            <= 32'd0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RX_STOP: begin
                    // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
                    if (cnt == bit_m1) begin
                        cnt <= 32'd0;
                        if (rx_s) begin
                            out_data   <= shreg;
                            data_valid <= 1'b1;
                            state      <= RX_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= RX_BREAK;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    cnt   <= 32'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at 16 clocks per bit: drivers push expected
// pulses (kind, byte, cycle) and a negedge monitor pops and compares them.
module tb_uart_rx_frame;

    localparam int CPB = 16;
    // Line falls just after posedge c: rx_s low after c+2, t0 = c+3, stop sample at t0+8+144.
    localparam int PULSE_LAT = 155;

    typedef struct {
        logic       fe;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       line;
    logic [7:0] out_data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    exp_t       sb[$];
    int         cyc;
    int         n_checks;
    int         n_fail;
    int         pulse_cnt;
    int         exp_pulses;
    logic [7:0] last_good;

    uart_rx_frame #(
        .baudrate (1),
        .base_clk (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .input_data_serial (line),
        .out_data          (out_data),
        .data_valid        (data_valid),
        .framing_error     (framing_error),
        .busy              (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (data_valid || framing_error)) begin
            exp_t e;
            pulse_cnt++;
            chk("pulse_exclusive", 32'(data_valid & framing_error), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: dv=%0b fe=%0b data=0x%02h, expected no pulse (cycle %0d)",
                         data_valid, framing_error, out_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind_fe", 32'(framing_error), 32'(e.fe));
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_pulse", 32'(busy), 32'(e.fe));
            end
        end
    end

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        e.fe = ~stop;
        if (stop) last_good = b;
        e.data = last_good;
        e.cyc  = cyc + PULSE_LAT;
        sb.push_back(e);
        exp_pulses++;
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) @(negedge clk);
            chk("busy_in_frame", 32'(busy), 32'd1);
        end
        line = stop;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        logic [7:0] partial;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        pulse_cnt  = 0;
        exp_pulses = 0;
        last_good  = 8'h00;
        rst        = 1'b1;
        line       = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_out_data", 32'(out_data), 32'h00);
        chk("reset_data_valid", 32'(data_valid), 32'd0);
        chk("reset_framing_error", 32'(framing_error), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(10);

        // Single good frame.
        send_frame(8'hA5, 1'b1);
        idle(20);
        chk("a5_held", 32'(out_data), 32'hA5);

        // Start glitch shorter than half a bit.
        line = 1'b0;
        repeat (5) @(negedge clk);
        idle(30);
        chk("glitch_out_data", 32'(out_data), 32'hA5);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_pulses", 32'(pulse_cnt), 32'(exp_pulses));

        // Framing error followed by a held-low (break) line.
        send_frame(8'h3C, 1'b0);
        repeat (24) @(negedge clk);
        chk("break_busy_high", 32'(busy), 32'd1);
        repeat (16) @(negedge clk);
        chk("break_busy_still_high", 32'(busy), 32'd1);
        idle(5);
        chk("break_busy_released", 32'(busy), 32'd0);
        chk("break_out_data", 32'(out_data), 32'hA5);
        idle(20);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(30);
        chk("b2b_pulses", 32'(pulse_cnt), 32'(exp_pulses));

        // Reset during data bit 4 of 0x5A, then 0xC3.
        partial = 8'h5A;
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line = partial[i];
            repeat (CPB) @(negedge clk);
        end
        line = partial[4];
        repeat (CPB / 2) @(negedge clk);
        rst  = 1'b1;
        line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        chk("midreset_out_data", 32'(out_data), 32'h00);
        chk("midreset_busy", 32'(busy), 32'd0);
        idle(20);
        send_frame(8'hC3, 1'b1);
        idle(30);
        chk("midreset_pulses", 32'(pulse_cnt), 32'(exp_pulses));

        // Loopback-style stream of every byte value.
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1'b1);
        end
        idle(30);

        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("total_pulses", 32'(pulse_cnt), 32'(exp_pulses));
        chk("final_out_data", 32'(out_data), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
